// File: rtl/pipeline_ir_chain.sv
// pipeline_ir_chain
// Instruction/PC register chain for a five-stage pipeline (IF -> DEC -> EXE ->
// MEM -> WB) with load-use and decode-resolve hazard detection, fetch flush
// and a global memory freeze.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   IF_IR      instruction from fetch
//   IF_PC      PC of IF_IR
//   CLEAR      taken branch/jump resolved in decode; flushes the fetched slot
//   MEM_BUSY   data memory not ready; freezes every stage
//   DEC_IR..WB_IR, DEC_PC..WB_PC   registered stage instruction/PC
//   PC_WRITE   fetch may advance (combinational)
//   HAZ_STALL  hazard stall indication (combinational)
//   STALL_CNT  saturating count of stall/freeze cycles

module pipeline_ir_chain #(
    parameter logic [31:0] NOP = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] IF_IR,
    input  logic [31:0] IF_PC,
    input  logic        CLEAR,
    input  logic        MEM_BUSY,
    output logic [31:0] DEC_IR,
    output logic [31:0] EXE_IR,
    output logic [31:0] MEM_IR,
    output logic [31:0] WB_IR,
    output logic [31:0] DEC_PC,
    output logic [31:0] EXE_PC,
    output logic [31:0] MEM_PC,
    output logic [31:0] WB_PC,
    output logic        PC_WRITE,
    output logic        HAZ_STALL,
    output logic [15:0] STALL_CNT
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic is_writer(input logic [31:0] ir);
        logic [6:0] opc;
        opc = ir[6:0];
        return (opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL) ||
               (opc == OPC_JALR) || (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
               (opc == OPC_LOAD) || ((opc == OPC_SYSTEM) && (ir[14:12] != 3'd0));
    endfunction

    function automatic logic uses_rs1(input logic [31:0] ir);
        logic [6:0] opc;
        opc = ir[6:0];
        return (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_OP_IMM) || (opc == OPC_OP) ||
               ((opc == OPC_SYSTEM) && !ir[14]);
    endfunction

    function automatic logic uses_rs2(input logic [31:0] ir);
        logic [6:0] opc;
        opc = ir[6:0];
        return (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);
    endfunction

    // True when rd of a producer is non-zero and feeds a source the consumer reads.
    function automatic logic rd_hits(input logic [31:0] prod, input logic [31:0] cons);
        logic [4:0] rd;
        rd = prod[11:7];
        return (rd != 5'd0) &&
               ((uses_rs1(cons) && (cons[19:15] == rd)) ||
                (uses_rs2(cons) && (cons[24:20] == rd)));
    endfunction

    logic [31:0] dec_ir_q, exe_ir_q, mem_ir_q, wb_ir_q;
    logic [31:0] dec_pc_q, exe_pc_q, mem_pc_q, wb_pc_q;
    logic [31:0] dec_ir_d, exe_ir_d, mem_ir_d, wb_ir_d;
    logic [31:0] dec_pc_d, exe_pc_d, mem_pc_d, wb_pc_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic dec_resolve;
    logic haz_stall;

    always_comb begin
        load_use    = (exe_ir_q[6:0] == OPC_LOAD) && rd_hits(exe_ir_q, dec_ir_q);
        dec_resolve = 1'b0;
        if ((dec_ir_q[6:0] == OPC_BRANCH) || (dec_ir_q[6:0] == OPC_JALR)) begin
            dec_resolve = (is_writer(exe_ir_q) && rd_hits(exe_ir_q, dec_ir_q)) ||
                          ((mem_ir_q[6:0] == OPC_LOAD) && rd_hits(mem_ir_q, dec_ir_q));
        end
        // A frozen pipeline cannot also stall; the hazard is re-evaluated on release.
        haz_stall = (load_use || dec_resolve) && !MEM_BUSY;
    end

    always_comb begin
        dec_ir_d = dec_ir_q;
        dec_pc_d = dec_pc_q;
        exe_ir_d = exe_ir_q;
        exe_pc_d = exe_pc_q;
        mem_ir_d = mem_ir_q;
        mem_pc_d = mem_pc_q;
        wb_ir_d  = wb_ir_q;
        wb_pc_d  = wb_pc_q;
        if (!MEM_BUSY) begin
            mem_ir_d = exe_ir_q;
            mem_pc_d = exe_pc_q;
            wb_ir_d  = mem_ir_q;
            wb_pc_d  = mem_pc_q;
            if (haz_stall) begin
                // DEC holds; CLEAR is ignored since decode operands are stale.
                exe_ir_d = NOP;
                exe_pc_d = 32'd0;
            end else begin
                exe_ir_d = dec_ir_q;
                exe_pc_d = dec_pc_q;
                if (CLEAR) begin
                    dec_ir_d = NOP;
                    dec_pc_d = 32'd0;
                end else begin
                    dec_ir_d = IF_IR;
                    dec_pc_d = IF_PC;
                end
            end
        end
        stall_cnt_d = stall_cnt_q;
        if ((MEM_BUSY || haz_stall) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_ir_q    <= NOP;
            exe_ir_q    <= NOP;
            mem_ir_q    <= NOP;
            wb_ir_q     <= NOP;
            dec_pc_q    <= 32'd0;
            exe_pc_q    <= 32'd0;
            mem_pc_q    <= 32'd0;
            wb_pc_q     <= 32'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            dec_ir_q    <= dec_ir_d;
            exe_ir_q    <= exe_ir_d;
            mem_ir_q    <= mem_ir_d;
            wb_ir_q     <= wb_ir_d;
            dec_pc_q    <= dec_pc_d;
            exe_pc_q    <= exe_pc_d;
            mem_pc_q    <= mem_pc_d;
            wb_pc_q     <= wb_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign DEC_IR    = dec_ir_q;
    assign EXE_IR    = exe_ir_q;
    assign MEM_IR    = mem_ir_q;
    assign WB_IR     = wb_ir_q;
    assign DEC_PC    = dec_pc_q;
    assign EXE_PC    = exe_pc_q;
    assign MEM_PC    = mem_pc_q;
    assign WB_PC     = wb_pc_q;
    assign HAZ_STALL = haz_stall;
    assign PC_WRITE  = !MEM_BUSY && !haz_stall;
    assign STALL_CNT = stall_cnt_q;

endmodule

// File: doc/pipeline_ir_chain.md
PIPELINE_IR_CHAIN -- requirements
Module: pipeline_ir_chain

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; all other inputs are synchronous to clk.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: rst_n  in  1  asynchronous active-low reset.
REQ-004 Port: IF_IR  in  32  instruction from fetch.
REQ-005 Port: IF_PC  in  32  PC of IF_IR.
REQ-006 Port: CLEAR  in  1  taken branch or jump resolved in decode; flushes fetch.
REQ-007 Port: MEM_BUSY  in  1  data memory not ready; freezes the whole chain.
REQ-008 Port: DEC_IR, EXE_IR, MEM_IR, WB_IR  out  32 each  stage instruction registers feeding the stage decoders.
REQ-009 Port: DEC_PC, EXE_PC, MEM_PC, WB_PC  out  32 each  stage PC registers.
REQ-010 Port: PC_WRITE  out  1  fetch may advance PC and accept the next instruction.
REQ-011 Port: HAZ_STALL  out  1  combinational hazard-stall indication.
REQ-012 Port: STALL_CNT  out  16  saturating count of stall cycles.
REQ-013 Parameter: NOP, default 32'h00000013, bubble instruction (addi x0,x0,0).

Function
REQ-014 Field extraction SHALL be: opcode=[6:0], rd=[11:7], f3=[14:12], rs1=[19:15], rs2=[24:20].
REQ-015 Writers SHALL be LUI, AUIPC, JAL, JALR, OP_IMM, OP, LOAD, and SYSTEM with f3!=0; a writer with rd=0 SHALL never cause a hazard.
REQ-016 rs1 SHALL be used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP, and SYSTEM with f3[2]=0; rs2 SHALL be used by BRANCH, STORE and OP.
REQ-017 Load-use hazard SHALL be flagged when EXE_IR is LOAD and its rd matches a used DEC_IR source.
REQ-018 Decode-resolve hazard SHALL be flagged when DEC_IR is BRANCH or JALR and either:
  - EXE_IR is any writer whose rd matches a used source; or
  - MEM_IR is LOAD whose rd matches a used source.
REQ-019 HAZ_STALL SHALL equal the OR of REQ-017 and REQ-018, gated off when MEM_BUSY=1.
REQ-020 PC_WRITE SHALL equal !MEM_BUSY && !HAZ_STALL.
REQ-021 Priority per cycle SHALL be MEM_BUSY > HAZ_STALL > CLEAR > normal advance.
REQ-022 MEM_BUSY=1 SHALL make every IR and PC register hold.
REQ-023 HAZ_STALL=1 SHALL:
  - make DEC hold;
  - load EXE with NOP and EXE_PC with 0;
  - advance MEM<-EXE and WB<-MEM;
  - ignore CLEAR, because decode operands are stale.
REQ-024 CLEAR=1 without stall SHALL load DEC with NOP and DEC_PC with 0, and advance EXE<-DEC, MEM<-EXE, WB<-MEM.
REQ-025 Normal advance SHALL be DEC<-IF, EXE<-DEC, MEM<-EXE, WB<-MEM, with the PCs alongside; latency from IF_IR to WB_IR is 4 cycles.
REQ-026 STALL_CNT SHALL increment by 1 on each rising edge with HAZ_STALL=1 or MEM_BUSY=1, and saturate at 16'hFFFF (no wrap).
REQ-027 All outputs other than HAZ_STALL and PC_WRITE SHALL be registered.

Reset
REQ-028 rst_n=0 SHALL immediately, independent of clk, set all IR registers to NOP, all PC registers and STALL_CNT to 0; PC_WRITE then evaluates 1 (absent MEM_BUSY).
REQ-029 Reset asserted mid-stall or mid-flush SHALL discard all in-flight state; the first edge after release SHALL perform a normal advance.

Verification
REQ-030 Straight line: four OP instructions at PC 0,4,8,C, no stalls -> instruction at PC 0 in WB_IR after 4 edges; STALL_CNT=0.
REQ-031 Load-use: EXE_IR=lw x5,0(x1), DEC_IR=add x6,x5,x7 -> HAZ_STALL=1, PC_WRITE=0; next edge EXE_IR=NOP, DEC_IR still add; STALL_CNT=1.
REQ-032 Branch after ALU op: EXE_IR=addi x3,x0,1, DEC_IR=beq x3,x0,L, CLEAR=1 -> stall wins: DEC holds, EXE_IR=NOP, CLEAR ignored; the following edge with CLEAR=1 -> DEC_IR=NOP, EXE_IR=beq.
REQ-033 rd=x0: EXE_IR=lw x0,0(x1), DEC_IR=add x2,x0,x0 -> HAZ_STALL=0, normal advance.
REQ-034 MEM_BUSY held 3 cycles together with a load-use condition -> all registers frozen, HAZ_STALL=0, STALL_CNT+3; after release the load-use stall occurs exactly once.
REQ-035 Async reset pulse between edges during a stall -> IRs read 32'h00000013 and STALL_CNT=0 before the next edge.
